// File: rtl/button_pkg.sv
// ============================================================================
// Module   : button_pkg
// Purpose  : Shared state type and counter-width helpers for button conditioning
// Revision : 1.0
// ============================================================================
`default_nettype none

package button_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      HOLD_DELAY  = 2'd1,
      HOLD_REPEAT = 2'd2
   } btn_state_t;

   function automatic int unsigned debounce_width(input int unsigned cycles);
      return $clog2(cycles + 1);
   endfunction

   function automatic int unsigned timer_width(input int unsigned delay,
                                               input int unsigned period);
      return (delay > period) ? $clog2(delay + 1) : $clog2(period + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/button_channel.sv
// ============================================================================
// Module   : button_channel
// Purpose  : One button: 2-flop synchronizer, debouncer, press/repeat pulse FSM
// Revision : 1.0
// ============================================================================
`default_nettype none

module button_channel
   import button_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 650000,
   parameter int unsigned REPEAT_EN       = 0,
   parameter int unsigned REPEAT_DELAY    = 32500000,
   parameter int unsigned REPEAT_PERIOD   = 6500000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_raw_i,
   output logic level_o,
   output logic pulse_o
);

   localparam int unsigned DB_W = debounce_width(DEBOUNCE_CYCLES);
   localparam int unsigned TM_W = timer_width(REPEAT_DELAY, REPEAT_PERIOD);

   localparam logic [DB_W-1:0] C_DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TM_W-1:0] C_DELAY_LAST  = TM_W'(REPEAT_DELAY - 1);
   localparam logic [TM_W-1:0] C_PERIOD_LAST = TM_W'(REPEAT_PERIOD - 1);
   localparam logic [TM_W-1:0] C_TM_MAX      = {TM_W{1'b1}};

   logic [1:0]      sync_q;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            level_q, level_d;
   btn_state_t      state_q, state_d;
   logic [TM_W-1:0] timer_q, timer_d;
   logic            pulse_q, pulse_d;
   logic [TM_W-1:0] w_timer_inc;

   always_comb begin
      db_cnt_d = '0;
      level_d  = level_q;
      if (sync_q[1] != level_q) begin
         if (db_cnt_q == C_DB_LAST) begin
            level_d = sync_q[1];
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end
   end

   assign w_timer_inc = (timer_q == C_TM_MAX) ? timer_q : timer_q + TM_W'(1);

   // The FSM looks at the next debounced level so the press pulse lands in the
   // same cycle the level rises, and a release suppresses any coincident repeat.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      pulse_d = 1'b0;
      if (!level_d) begin
         state_d = IDLE;
         timer_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!level_q) begin
                  pulse_d = 1'b1;
                  timer_d = '0;
                  state_d = HOLD_DELAY;
               end
            end
            HOLD_DELAY: begin
               if (REPEAT_EN != 0) begin
                  if (timer_q == C_DELAY_LAST) begin
                     pulse_d = 1'b1;
                     timer_d = '0;
                     state_d = HOLD_REPEAT;
                  end else begin
                     timer_d = w_timer_inc;
                  end
               end
            end
            HOLD_REPEAT: begin
               if (timer_q == C_PERIOD_LAST) begin
                  pulse_d = 1'b1;
                  timer_d = '0;
               end else begin
                  timer_d = w_timer_inc;
               end
            end
            default: begin
               state_d = IDLE;
               timer_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q   <= '0;
         db_cnt_q <= '0;
         level_q  <= 1'b0;
         state_q  <= IDLE;
         timer_q  <= '0;
         pulse_q  <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], btn_raw_i};
         db_cnt_q <= db_cnt_d;
         level_q  <= level_d;
         state_q  <= state_d;
         timer_q  <= timer_d;
         pulse_q  <= pulse_d;
      end
   end

   assign level_o = level_q;
   assign pulse_o = pulse_q;

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// Module   : button_conditioner
// Purpose  : Array of independent debounced button channels with press/repeat pulses
// Revision : 1.0
// ============================================================================
`default_nettype none

module button_conditioner #(
   parameter int unsigned NUM_BTNS        = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 650000,
   parameter int unsigned REPEAT_EN       = 0,
   parameter int unsigned REPEAT_DELAY    = 32500000,
   parameter int unsigned REPEAT_PERIOD   = 6500000
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic [NUM_BTNS-1:0] btn_raw_in,
   output logic [NUM_BTNS-1:0] btn_level,
   output logic [NUM_BTNS-1:0] btn_pulse
);

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
      button_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_EN      (REPEAT_EN),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_channel (
         .clk_i    (clk_in),
         .rst_ni   (rst_n_in),
         .btn_raw_i(btn_raw_in[i]),
         .level_o  (btn_level[i]),
         .pulse_o  (btn_pulse[i])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
// Module   : tb_button_conditioner
// Purpose  : Self-checking bench for button_conditioner, with and without auto-repeat
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_button_conditioner;

   localparam int NB = 2;
   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic [NB-1:0] raw   = '0;
   logic [NB-1:0] lvl0, pul0, lvl1, pul1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   button_conditioner #(
      .NUM_BTNS(NB), .DEBOUNCE_CYCLES(DB), .REPEAT_EN(0),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut_norep (
      .clk_in(clk), .rst_n_in(rst_n), .btn_raw_in(raw),
      .btn_level(lvl0), .btn_pulse(pul0)
   );

   button_conditioner #(
      .NUM_BTNS(NB), .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut_rep (
      .clk_in(clk), .rst_n_in(rst_n), .btn_raw_in(raw),
      .btn_level(lvl1), .btn_pulse(pul1)
   );

   // Reference model: the level follows raw once the last DB synchronized
   // samples (raw delayed by two edges) all disagree with it; pulses come from
   // the elapsed time since the press.
   logic [NB-1:0] samp_q[$];
   logic [NB-1:0] m_lvl, m_pul0, m_pul1;
   int            edge_n;
   int            t_press[NB];

   function automatic logic [NB-1:0] f_next_level();
      logic [NB-1:0] nl;
      logic          all_diff;
      int            sz;
      sz = samp_q.size();
      for (int b = 0; b < NB; b++) begin
         all_diff = 1'b1;
         for (int j = 0; j < DB; j++)
            if (samp_q[sz-3-j][b] == m_lvl[b]) all_diff = 1'b0;
         nl[b] = all_diff ? ~m_lvl[b] : m_lvl[b];
      end
      return nl;
   endfunction

   function automatic logic [NB-1:0] f_rep_pulse(input logic [NB-1:0] nl, input int en);
      logic [NB-1:0] p;
      int            d;
      for (int b = 0; b < NB; b++) begin
         d    = en - t_press[b];
         p[b] = 1'b0;
         if (nl[b] && !m_lvl[b]) p[b] = 1'b1;
         else if (nl[b])         p[b] = (d == RD) || (d > RD && ((d - RD) % RP) == 0);
      end
      return p;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         samp_q.delete();
         for (int i = 0; i < DB + 3; i++) samp_q.push_back('0);
         m_lvl  <= '0;
         m_pul0 <= '0;
         m_pul1 <= '0;
         edge_n <= 0;
         for (int b = 0; b < NB; b++) t_press[b] <= 0;
      end else begin
         samp_q.push_back(raw);
         for (int b = 0; b < NB; b++)
            if (f_next_level() [b] && !m_lvl[b]) t_press[b] <= edge_n + 1;
         m_pul0 <= f_next_level() & ~m_lvl;
         m_pul1 <= f_rep_pulse(f_next_level(), edge_n + 1);
         m_lvl  <= f_next_level();
         edge_n <= edge_n + 1;
         while (samp_q.size() > DB + 3) samp_q.pop_front();
      end
   end

   task automatic test_reset();
      #2;
      raw   = 2'b11;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({lvl0, pul0, lvl1, pul1} !== 8'h00) begin
         errors++;
         $display("FAIL reset_async: got lvl0=%b pul0=%b lvl1=%b pul1=%b expected all 0", lvl0, pul0, lvl1, pul1);
      end
      repeat (3) @(negedge clk);
      raw   = '0;
      rst_n = 1'b1;
      for (int k = 0; k < DB + 4; k++) begin
         @(negedge clk);
         checks++;
         if ({lvl0, pul0, lvl1, pul1} !== 8'h00) begin
            errors++;
            $display("FAIL reset_idle: k=%0d got lvl0=%b pul0=%b lvl1=%b pul1=%b expected all 0", k, lvl0, pul0, lvl1, pul1);
         end
      end
   endtask

   task automatic test_clean_press();
      logic el, ep;
      raw = 2'b01;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         el = (k >= DB + 1);
         ep = (k == DB + 1);
         checks++;
         if ({lvl0[0], pul0[0]} !== {el, ep}) begin
            errors++;
            $display("FAIL clean_press: k=%0d got level=%b pulse=%b expected level=%b pulse=%b", k, lvl0[0], pul0[0], el, ep);
         end
         checks++;
         if ({lvl0, pul0, lvl1, pul1} !== {m_lvl, m_pul0, m_lvl, m_pul1}) begin
            errors++;
            $display("FAIL clean_press_model: k=%0d got %b/%b/%b/%b expected %b/%b/%b/%b", k, lvl0, pul0, lvl1, pul1, m_lvl, m_pul0, m_lvl, m_pul1);
         end
      end
      raw = 2'b00;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         el = (k < DB + 1);
         checks++;
         if ({lvl0[0], pul0[0]} !== {el, 1'b0}) begin
            errors++;
            $display("FAIL clean_release: k=%0d got level=%b pulse=%b expected level=%b pulse=0", k, lvl0[0], pul0[0], el);
         end
      end
   endtask

   task automatic test_bounce();
      logic [8:0] pat;
      int         np0, np1;
      pat = 9'b101101110;
      np0 = 0;
      np1 = 0;
      for (int i = 8; i >= 0; i--) begin
         raw = {1'b0, pat[i]};
         @(negedge clk);
         np0 += int'(pul0[0]);
         np1 += int'(pul1[0]);
         checks++;
         if ({lvl0[0], pul0[0], lvl1[0], pul1[0]} !== 4'b0000) begin
            errors++;
            $display("FAIL bounce_quiet: i=%0d got lvl0=%b pul0=%b lvl1=%b pul1=%b expected 0", i, lvl0[0], pul0[0], lvl1[0], pul1[0]);
         end
      end
      raw = 2'b01;
      for (int k = 0; k < 30; k++) begin
         if (k == 10) raw = 2'b00;
         @(negedge clk);
         np0 += int'(pul0[0]);
         np1 += int'(pul1[0]);
         checks++;
         if ({lvl0, pul0, lvl1, pul1} !== {m_lvl, m_pul0, m_lvl, m_pul1}) begin
            errors++;
            $display("FAIL bounce_model: k=%0d got %b/%b/%b/%b expected %b/%b/%b/%b", k, lvl0, pul0, lvl1, pul1, m_lvl, m_pul0, m_lvl, m_pul1);
         end
      end
      checks++;
      if (np0 != 1 || np1 != 1) begin
         errors++;
         $display("FAIL bounce_pulse_count: got norep=%0d rep=%0d expected 1 and 1", np0, np1);
      end
   endtask

   task automatic test_auto_repeat();
      logic el, ep;
      int   off, np;
      np  = 0;
      raw = 2'b01;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         off = k - (DB + 1);
         el  = (k >= DB + 1) && (k < 35);
         ep  = el && (off == 0 || off == RD || (off > RD && ((off - RD) % RP) == 0));
         np += int'(pul1[0]);
         checks++;
         if ({lvl1[0], pul1[0]} !== {el, ep}) begin
            errors++;
            $display("FAIL auto_repeat: k=%0d got level=%b pulse=%b expected level=%b pulse=%b", k, lvl1[0], pul1[0], el, ep);
         end
         checks++;
         if ({lvl0, pul0, lvl1, pul1} !== {m_lvl, m_pul0, m_lvl, m_pul1}) begin
            errors++;
            $display("FAIL auto_repeat_model: k=%0d got %b/%b/%b/%b expected %b/%b/%b/%b", k, lvl0, pul0, lvl1, pul1, m_lvl, m_pul0, m_lvl, m_pul1);
         end
         if (k == 29) raw = 2'b00;
      end
      checks++;
      if (np != 8) begin
         errors++;
         $display("FAIL auto_repeat_count: got %0d pulses expected 8", np);
      end
   endtask

   task automatic test_simultaneous();
      logic ep;
      int   off;
      raw = 2'b11;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         off = k - (DB + 1);
         ep  = (k >= DB + 1) && (k < 45) &&
               (off == 0 || off == RD || (off > RD && ((off - RD) % RP) == 0));
         if (k < 20) begin
            checks++;
            if ({lvl1[1], pul1[1], lvl0[1], pul0[1]} !== {lvl1[0], pul1[0], lvl0[0], pul0[0]}) begin
               errors++;
               $display("FAIL simultaneous_match: k=%0d got bit1=%b%b%b%b bit0=%b%b%b%b expected equal", k, lvl1[1], pul1[1], lvl0[1], pul0[1], lvl1[0], pul1[0], lvl0[0], pul0[0]);
            end
         end
         checks++;
         if (pul1[0] !== ep) begin
            errors++;
            $display("FAIL simultaneous_bit0: k=%0d got pulse=%b expected %b", k, pul1[0], ep);
         end
         checks++;
         if ({lvl0, pul0, lvl1, pul1} !== {m_lvl, m_pul0, m_lvl, m_pul1}) begin
            errors++;
            $display("FAIL simultaneous_model: k=%0d got %b/%b/%b/%b expected %b/%b/%b/%b", k, lvl0, pul0, lvl1, pul1, m_lvl, m_pul0, m_lvl, m_pul1);
         end
         if (k == 19) raw = 2'b01;
         if (k == 39) raw = 2'b00;
      end
   endtask

   task automatic test_reset_mid_hold();
      logic ep;
      int   off;
      raw = 2'b01;
      repeat (21) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({lvl0, pul0, lvl1, pul1} !== 8'h00) begin
         errors++;
         $display("FAIL midhold_async: got lvl0=%b pul0=%b lvl1=%b pul1=%b expected all 0", lvl0, pul0, lvl1, pul1);
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++;
         if ({lvl0, pul0, lvl1, pul1} !== 8'h00) begin
            errors++;
            $display("FAIL midhold_in_reset: k=%0d got %b/%b/%b/%b expected all 0", k, lvl0, pul0, lvl1, pul1);
         end
      end
      rst_n = 1'b1;
      for (int k = 0; k < 31; k++) begin
         @(negedge clk);
         off = k - (DB + 1);
         ep  = (k >= DB + 1) &&
               (off == 0 || off == RD || (off > RD && ((off - RD) % RP) == 0));
         checks++;
         if ({lvl1[0], pul1[0]} !== {(k >= DB + 1) ? 1'b1 : 1'b0, ep}) begin
            errors++;
            $display("FAIL midhold_restart: k=%0d got level=%b pulse=%b expected pulse=%b", k, lvl1[0], pul1[0], ep);
         end
         checks++;
         if ({lvl0, pul0, lvl1, pul1} !== {m_lvl, m_pul0, m_lvl, m_pul1}) begin
            errors++;
            $display("FAIL midhold_model: k=%0d got %b/%b/%b/%b expected %b/%b/%b/%b", k, lvl0, pul0, lvl1, pul1, m_lvl, m_pul0, m_lvl, m_pul1);
         end
      end
      raw = 2'b00;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_random();
      int cnt[NB];
      for (int b = 0; b < NB; b++) cnt[b] = $urandom_range(1, 25);
      for (int k = 0; k < 800; k++) begin
         for (int b = 0; b < NB; b++) begin
            cnt[b]--;
            if (cnt[b] <= 0) begin
               raw[b] = ~raw[b];
               cnt[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(1, 30);
            end
         end
         @(negedge clk);
         checks++;
         if ({lvl0, pul0, lvl1, pul1} !== {m_lvl, m_pul0, m_lvl, m_pul1}) begin
            errors++;
            $display("FAIL random_model: k=%0d raw=%b got %b/%b/%b/%b expected %b/%b/%b/%b", k, raw, lvl0, pul0, lvl1, pul1, m_lvl, m_pul0, m_lvl, m_pul1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_auto_repeat();
      test_simultaneous();
      repeat (20) @(negedge clk);
      test_reset_mid_hold();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
